// File: rtl/drift_table_buffer.sv
// drift_table_buffer: double-buffered capture of generator drift tables with random-access readback
module drift_table_buffer #(
  parameter int T_MAX = 511,
  parameter int LOGT  = 9,
  parameter int DW    = 18
) (
  input  logic            CLK,
  input  logic            iRst_n,
  input  logic [DW-1:0]   iData,
  input  logic [LOGT-1:0] iAddr,
  input  logic            iValid,
  input  logic            iDone,
  input  logic            iRdEn,
  input  logic [LOGT-1:0] iRdAddr,
  input  logic            iRelease,
  output logic [DW-1:0]   oRdData,
  output logic            oRdValid,
  output logic            oBankReady,
  output logic            oBusy,
  output logic            oOverrun,
  output logic            oSeqErr
);
  localparam logic [LOGT:0] LEN = (LOGT+1)'(T_MAX + 1);
  logic [DW-1:0] bank0 [2**LOGT];
  logic [DW-1:0] bank1 [2**LOGT];
  logic [1:0] full, full_set, full_clr;
  logic wr_bank, rd_bank, bad, bad_next;
  logic [LOGT:0] wr_cnt, cnt_next;
  logic accept, done, commit, rel, rd_ok;
  always_comb begin
    accept = iValid && !full[wr_bank];
    cnt_next = wr_cnt + (LOGT+1)'(accept);
    bad_next = bad || (accept && (iAddr != wr_cnt[LOGT-1:0] || wr_cnt >= LEN));
    // an iDone against a full write bank only closes a run of dropped samples
    done = iDone && !full[wr_bank];
    commit = done && !bad_next && cnt_next == LEN;
    rel = iRelease && full[rd_bank];
    rd_ok = iRdEn && full[rd_bank];
    full_set = commit ? 2'b01 << wr_bank : 2'b00;
    full_clr = rel ? 2'b01 << rd_bank : 2'b00;
  end
  always_ff @(posedge CLK) begin
    if (accept && !wr_bank) bank0[iAddr] <= iData;
    if (accept && wr_bank) bank1[iAddr] <= iData;
  end
  always_ff @(posedge CLK) begin
    if (!iRst_n) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      bad <= 1'b0;
      oOverrun <= 1'b0;
      oSeqErr <= 1'b0;
      oRdValid <= 1'b0;
      oRdData <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      wr_bank <= wr_bank ^ commit;
      rd_bank <= rd_bank ^ rel;
      wr_cnt <= done ? '0 : cnt_next;
      bad <= done ? 1'b0 : bad_next;
      oOverrun <= oOverrun | (iValid & full[wr_bank]);
      oSeqErr <= oSeqErr | (done & !commit);
      oRdValid <= rd_ok;
      if (rd_ok) oRdData <= rd_bank ? bank1[iRdAddr] : bank0[iRdAddr];
    end
  end
  assign oBankReady = full[rd_bank];
  assign oBusy = wr_cnt != '0;
endmodule

// File: doc/drift_table_buffer.md
# drift_table_buffer

Double-buffered capture stage that sits directly downstream of the S0·exp(t·mu) drift generator. It accepts the generator's streamed (address, data, valid, done) output and writes one complete table of T_MAX+1 drift samples into a bank. It commits the bank only when the stream is complete and in order. It then serves random-access reads of the committed table to the Monte Carlo path stage while the next table fills the other bank.

## Interface
- T_MAX, 511, last table index; table length is T_MAX+1
- LOGT, 9, address width; 2^LOGT ≥ T_MAX+1
- DW, 18, sample width (3 integer, 15 fraction bits; passed through unmodified)

Ports:
- CLK  in  1  clock; all logic on rising edge
- iRst_n  in  1  synchronous, active-low reset
- iData  in  DW  drift sample from generator
- iAddr  in  LOGT  sample index t from generator
- iValid  in  1  iData/iAddr valid this cycle
- iDone  in  1  one-cycle pulse: generator finished the table
- iRdEn  in  1  read request from path stage
- iRdAddr  in  LOGT  read index
- iRelease  in  1  one-cycle pulse: path stage finished with current read bank
- oRdData  out  DW  read data
- oRdValid  out  1  oRdData valid
- oBankReady  out  1  current read bank holds a committed table
- oBusy  out  1  write side has accepted ≥1 sample of an uncommitted table
- oOverrun  out  1  sticky: a sample arrived with both banks full
- oSeqErr  out  1  sticky: out-of-order address or short/long table at iDone

## Operation
- Storage: two banks, each 2^LOGT × DW, single write port, single read port. Contents are not reset.
- State: full[1:0], wr_bank, rd_bank, wr_cnt (LOGT+1 bits), bad (per-fill sequence flag).
- Write side:
  - If iValid and !full[wr_bank]: write iData to bank[wr_bank][iAddr], then wr_cnt++.
  - If iAddr != wr_cnt[LOGT-1:0] or wr_cnt > T_MAX: set bad. The write is still performed.
  - If iValid and full[wr_bank]: drop the sample, set oOverrun. wr_cnt is unchanged.
- Commit on iDone. If iValid occurs in the same cycle, that sample is accepted first and included in the count.
  - If !bad and the final count == T_MAX+1 and !full[wr_bank]: set full[wr_bank], toggle wr_bank.
  - Otherwise: set oSeqErr, leave full[wr_bank] clear so the bank is discarded and refilled.
  - In either case, clear wr_cnt and bad.
  - An iDone that follows only dropped samples (bank full) changes nothing further.
- Read side:
  - oBankReady = full[rd_bank].
  - iRdEn with oBankReady: read bank[rd_bank][iRdAddr]. iRdEn without oBankReady is ignored.
  - iRelease with oBankReady: clear full[rd_bank], toggle rd_bank. iRelease without oBankReady is ignored.
- Simultaneous events:
  - Commit and release target different banks; both take effect in the same cycle.
  - iRdEn and iRelease in the same cycle: the read uses the old rd_bank.
- oBusy = (wr_cnt != 0).
- Sticky flags clear only on reset.

## Timing
- Reset (iRst_n low at edge): full=0, wr_bank=rd_bank=0, wr_cnt=0, bad=0. All outputs are 0 the next cycle: oRdData=0, oRdValid=0, oBankReady=0, oBusy=0, oOverrun=0, oSeqErr=0.
- Reset mid-fill discards the partial table. Reset mid-read discards committed banks.
- Write: a sample is stored at the edge where iValid is high, so it is readable once committed.
- Commit: full is set at the iDone edge; oBankReady rises in the following cycle.
- Read latency is 1 cycle: iRdEn at edge N → oRdData/oRdValid valid after edge N+1. oRdValid is high for exactly 1 cycle per accepted read. oRdData holds its value when oRdValid is low.
- Back-to-back reads sustain one per cycle.
- Release: oBankReady reflects the other bank in the cycle after iRelease.
- Throughput: one sample per cycle on the write side. No backpressure to the generator exists, so it must not restart while both banks are full (reported via oOverrun).

## Test plan
- Reset: hold iRst_n=0 for 2 cycles with random inputs → every output is 0. Release reset → outputs remain 0.
- Nominal fill/read: stream t=0..511, iData=3·t, then iDone → oBankReady=1 one cycle later. iRdEn with iRdAddr=100 → next cycle oRdData=300, oRdValid=1. Read 511 → 1533.
- Ping-pong: fill table A (data=t), fill table B (data=t+1000) with no release → oBankReady stays 1 and address 5 reads 5. iRelease → next read of address 5 returns 1005. A third fill after iRelease commits into bank 0.
- Overrun: both banks full, stream a third table → oOverrun=1, no commit, bank 0 address 5 still reads 5.
- Short/out-of-order table: iDone after 300 samples → oSeqErr=1, oBankReady=0. Separately, address 5 followed by 7 → oSeqErr=1 and bank discarded. A following clean 512-sample fill commits normally.
- Mid-fill reset and simultaneity: pulse reset at sample 200 → clean refill commits. iDone and iRelease in the same cycle → both banks' full bits update correctly.
